// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-request initiator for an asynchronous memory, sequencing setup/access/hold phases
module mem_access_ctrl #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic                  read_write,
  output logic                  chip_en,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy
);
  localparam int CW = $clog2(WAIT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic accept, done;
  assign req_ready = state == IDLE;
  assign busy      = state != IDLE;
  assign accept    = req_valid && req_ready;
  assign done      = state == ACCESS && cnt == '0;
  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  // phase sequencing: one setup cycle, WAIT_CYCLES access cycles, one hold cycle
  always_comb begin
    state_nxt = state == IDLE   ? (accept ? SETUP : IDLE) :
                state == SETUP  ? ACCESS :
                state == ACCESS ? (done ? HOLD : ACCESS) : IDLE;
  end
  // memory pins, wait counter and response; pins stay put after the hold phase
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      address    <= '0;
      data_in    <= '0;
      read_write <= 1'b0;
      chip_en    <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      cnt        <= '0;
    end else begin
      chip_en   <= state == SETUP || (state == ACCESS && cnt != '0);
      rsp_valid <= done;
      if (state == SETUP) cnt <= CW'(WAIT_CYCLES - 1);
      else if (state == ACCESS && cnt != '0) cnt <= cnt - 1'b1;
      if (accept) begin
        address    <= req_addr;
        data_in    <= req_write ? req_wdata : '0;
        read_write <= req_write;
      end
      if (done) rsp_rdata <= read_write ? '0 : data_out;
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: scoreboard bench for mem_access_ctrl with a behavioural memory
module tb_mem_access_ctrl;
  logic clk = 1'b0, reset_n = 1'b0;
  always #5 clk = ~clk;
  logic       req_valid = 1'b0, req_write = 1'b0;
  logic [7:0] req_addr = '0, req_wdata = '0;
  logic       req_ready, rsp_valid, read_write, chip_en, busy;
  logic [7:0] rsp_rdata, address, data_in, data_out;
  logic [7:0] mem [256];
  logic [7:0] exp_mem [256];
  logic [7:0] sbq [$];
  int checks = 0, failures = 0, n_acc = 0, n_rsp = 0, cyc = 0;

  mem_access_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .address(address), .data_in(data_in),
    .read_write(read_write), .chip_en(chip_en), .data_out(data_out), .busy(busy));

  logic       v_valid = 1'b0, v_write = 1'b0;
  logic [7:0] v_addr = '0, v_wdata = '0;
  logic       rdy1, rv1, rw1, ce1, bz1, rdy4, rv4, rw4, ce4, bz4;
  logic [7:0] rd1, ad1, di1, rd4, ad4, di4;

  mem_access_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .req_valid(v_valid), .req_ready(rdy1),
    .req_write(v_write), .req_addr(v_addr), .req_wdata(v_wdata),
    .rsp_valid(rv1), .rsp_rdata(rd1), .address(ad1), .data_in(di1),
    .read_write(rw1), .chip_en(ce1), .data_out(8'hC3), .busy(bz1));

  mem_access_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .WAIT_CYCLES(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .req_valid(v_valid), .req_ready(rdy4),
    .req_write(v_write), .req_addr(v_addr), .req_wdata(v_wdata),
    .rsp_valid(rv4), .rsp_rdata(rd4), .address(ad4), .data_in(di4),
    .read_write(rw4), .chip_en(ce4), .data_out(8'hC3), .busy(bz4));

  // behavioural asynchronous memory
  assign data_out = mem[address];
  always @(posedge clk) if (chip_en && read_write) mem[address] <= data_in;

  always @(posedge clk) cyc++;

  // push the expected response when a request is accepted
  always @(posedge clk)
    if (reset_n && req_valid && req_ready) begin
      n_acc++;
      if (req_write) begin
        exp_mem[req_addr] = req_wdata;
        sbq.push_back(8'h00);
      end else sbq.push_back(exp_mem[req_addr]);
    end

  // pop and compare on every response pulse
  always @(negedge clk)
    if (rsp_valid) begin
      logic [7:0] e;
      n_rsp++;
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL rsp_unexpected: got rsp_rdata=%h, required no response", rsp_rdata);
      end else begin
        e = sbq.pop_front();
        if (rsp_rdata !== e) begin
          failures++;
          $display("FAIL rsp_rdata: got %h, required %h", rsp_rdata, e);
        end
      end
    end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic run_txn(input logic w, input logic [7:0] a, input logic [7:0] d,
                         output logic [5:0] ce, output logic [5:0] rv,
                         output logic [5:0] rdy, output logic pins_ok);
    pins_ok = 1'b1;
    req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) req_valid = 1'b0;
      ce[k] = chip_en; rv[k] = rsp_valid; rdy[k] = req_ready;
      if (k < 4 && (address !== a || read_write !== w || data_in !== (w ? d : 8'h00) || busy !== 1'b1))
        pins_ok = 1'b0;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({address, data_in, read_write, chip_en} !== 18'h0) begin
      failures++;
      $display("FAIL reset_pins: got %h, required 0", {address, data_in, read_write, chip_en});
    end
    checks++;
    if ({req_ready, busy, rsp_valid, rsp_rdata} !== {3'b100, 8'h00}) begin
      failures++;
      $display("FAIL reset_status: got %b, required 100_00000000", {req_ready, busy, rsp_valid, rsp_rdata});
    end
  endtask

  task automatic test_write;
    logic [5:0] ce, rv, rdy;
    logic ok;
    run_txn(1'b1, 8'h3C, 8'hA5, ce, rv, rdy, ok);
    checks++;
    if (ce !== 6'b000110) begin failures++; $display("FAIL write_chip_en: got %b, required 000110", ce); end
    checks++;
    if (rv !== 6'b001000) begin failures++; $display("FAIL write_rsp_valid: got %b, required 001000", rv); end
    checks++;
    if (rdy !== 6'b110000) begin failures++; $display("FAIL write_req_ready: got %b, required 110000", rdy); end
    checks++;
    if (ok !== 1'b1) begin failures++; $display("FAIL write_pins_held: got %b, required 1", ok); end
  endtask

  task automatic test_read;
    logic [5:0] ce, rv, rdy;
    logic ok;
    run_txn(1'b0, 8'h3C, 8'h77, ce, rv, rdy, ok);
    checks++;
    if (ok !== 1'b1) begin failures++; $display("FAIL read_pins_held: got %b, required 1", ok); end
    checks++;
    if (rv !== 6'b001000) begin failures++; $display("FAIL read_rsp_valid: got %b, required 001000", rv); end
    checks++;
    if (rsp_rdata !== 8'hA5) begin failures++; $display("FAIL read_rdata_held: got %h, required a5", rsp_rdata); end
  endtask

  task automatic test_back_to_back;
    logic       ws [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0] as [6] = '{8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF};
    logic [7:0] ds [6] = '{8'h11, 8'h00, 8'h22, 8'h00, 8'h33, 8'h00};
    int acc [6];
    int a0 = n_acc, r0 = n_rsp, t;
    req_write = ws[0]; req_addr = as[0]; req_wdata = ds[0]; req_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      t = 0;
      while (!req_ready && t < 20) begin @(negedge clk); t++; end
      if (t >= 20) begin
        checks++; failures++;
        $display("FAIL b2b_accept_timeout: request %0d not accepted within 20 cycles", i);
        break;
      end
      acc[i] = cyc + 1;
      @(negedge clk);
      if (i == 5) req_valid = 1'b0;
      else begin req_write = ws[i+1]; req_addr = as[i+1]; req_wdata = ds[i+1]; end
    end
    req_valid = 1'b0;
    for (int i = 1; i < 6; i++) begin
      checks++;
      if (acc[i] - acc[i-1] !== 5) begin
        failures++;
        $display("FAIL b2b_spacing[%0d]: got %0d cycles, required 5", i, acc[i] - acc[i-1]);
      end
    end
    repeat (10) @(negedge clk);
    checks++;
    if (n_acc - a0 !== 6) begin failures++; $display("FAIL b2b_accepts: got %0d, required 6", n_acc - a0); end
    checks++;
    if (n_rsp - r0 !== 6) begin failures++; $display("FAIL b2b_responses: got %0d, required 6", n_rsp - r0); end
  endtask

  task automatic test_reset_mid;
    logic seen = 1'b0;
    @(negedge clk);
    req_write = 1'b1; req_addr = 8'h77; req_wdata = 8'h99; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #2;
    checks++;
    if (chip_en !== 1'b1) begin failures++; $display("FAIL abort_access_entered: got chip_en=%b, required 1", chip_en); end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({chip_en, busy} !== 2'b00) begin failures++; $display("FAIL abort_immediate: got chip_en,busy=%b, required 00", {chip_en, busy}); end
    sbq.delete();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) begin @(negedge clk); if (rsp_valid) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_rsp: got rsp_valid seen=%b, required 0", seen); end
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL abort_ready: got %b, required 1", req_ready); end
  endtask

  task automatic test_wait_variants;
    int n1 = 0, n4 = 0, l1 = -1, l4 = -1;
    v_write = 1'b0; v_addr = 8'h05; v_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) v_valid = 1'b0;
      n1 += int'(ce1); n4 += int'(ce4);
      if (rv1 && l1 < 0) l1 = k;
      if (rv4 && l4 < 0) l4 = k;
    end
    checks++;
    if (n1 !== 1) begin failures++; $display("FAIL w1_chip_en_cycles: got %0d, required 1", n1); end
    checks++;
    if (n4 !== 4) begin failures++; $display("FAIL w4_chip_en_cycles: got %0d, required 4", n4); end
    checks++;
    if (l1 !== 2) begin failures++; $display("FAIL w1_latency: got %0d, required 2", l1); end
    checks++;
    if (l4 !== 5) begin failures++; $display("FAIL w4_latency: got %0d, required 5", l4); end
    checks++;
    if ({rd1, rd4} !== 16'hC3C3) begin failures++; $display("FAIL wvar_rdata: got %h, required c3c3", {rd1, rd4}); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'(i) ^ 8'h5A;
      exp_mem[i] = 8'(i) ^ 8'h5A;
    end
    test_reset;
    test_write;
    test_read;
    test_back_to_back;
    test_reset_mid;
    test_wait_variants;
    repeat (3) @(negedge clk);
    checks++;
    if (sbq.size() !== 0) begin failures++; $display("FAIL sb_drained: got %0d pending, required 0", sbq.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
